// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with optional skid entry, sync flush and saturating stall counter.
// An empty stage drives all-zero data so downstream decoders see a NOP bubble.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [1:0]             occ,
  output logic [CNT_W-1:0]       stall_cnt
);
  localparam int DW = NCH * WIDTH;
  logic          main_v, skid_v;
  logic [DW-1:0] main_d, skid_d;
  logic          accept, emit;
  // With a skid entry in_ready depends only on state, breaking the out_ready->in_ready path
  assign in_ready  = (SKID != 0) ? !skid_v : (!main_v || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_v ? main_d : '0;
  assign occ       = {1'b0, main_v} + {1'b0, skid_v};
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (skid_v) begin
      if (emit) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (!main_v || emit) begin
      main_v <= accept;
      if (accept) main_d <= in_data;
    end else if (accept && SKID != 0) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) stall_cnt <= '0;
    else if (main_v && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of the default skid stage, a 4-bit stall counter and a SKID=0 narrow stage.
module tb_pipe_stage_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr_n;
  int n_tests = 0, n_fail = 0;
  logic a_flush, a_iv, a_ir, a_ov, a_or;
  logic [127:0] a_id, a_od;
  logic [1:0] a_occ;
  logic [15:0] a_sc;
  logic b_iv, b_ir, b_ov, b_or;
  logic [127:0] b_id, b_od;
  logic [1:0] b_occ;
  logic [3:0] b_sc;
  logic c_iv, c_ir, c_ov, c_or;
  logic [15:0] c_id, c_od;
  logic [1:0] c_occ;
  logic [15:0] c_sc;
  pipe_stage_buf u_a (
    .clk(clk), .clr_n(clr_n), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occ(a_occ), .stall_cnt(a_sc));
  pipe_stage_buf #(.CNT_W(4)) u_b (
    .clk(clk), .clr_n(clr_n), .flush(1'b0), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occ(b_occ), .stall_cnt(b_sc));
  pipe_stage_buf #(.WIDTH(8), .NCH(2), .SKID(0)) u_c (
    .clk(clk), .clr_n(clr_n), .flush(1'b0), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .occ(c_occ), .stall_cnt(c_sc));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] beat(input logic [31:0] f0);
    return {32'h3333, 32'hBEEF, 32'h1111, f0};
  endfunction
  function automatic logic [15:0] cbeat(input int k);
    return {8'(8'h30 + k), 8'(8'h40 + k)};
  endfunction
  initial begin
    int snd, rcv, cyc;
    logic acc;
    clr_n = 1'b0;
    {a_flush, a_iv, a_or, b_iv, b_or, c_iv, c_or} = '0;
    a_id = '0; b_id = '0; c_id = '0;
    #12;
    chk("rst_ov", 128'(a_ov), 128'(0));
    chk("rst_od", a_od, 128'(0));
    chk("rst_occ", 128'(a_occ), 128'(0));
    chk("rst_sc", 128'(a_sc), 128'(0));
    chk("rst_ir", 128'(a_ir), 128'(1));
    @(negedge clk) clr_n = 1'b1;
    step();
    a_or = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_iv = 1'b1;
      a_id = beat(32'(32'h1000 + i));
      step();
      chk("str_od", a_od, beat(32'(32'h1000 + i)));
      chk("str_ir", 128'(a_ir), 128'(1));
      chk("str_occ", 128'(a_occ), 128'(1));
    end
    a_iv = 1'b0;
    step();
    chk("str_end_ov", 128'(a_ov), 128'(0));
    chk("str_end_od", a_od, 128'(0));
    chk("str_sc", 128'(a_sc), 128'(0));
    a_or = 1'b0; a_iv = 1'b1; a_id = beat(32'hA);
    step();
    chk("stl_A_od", a_od, beat(32'hA));
    chk("stl_A_sc", 128'(a_sc), 128'(0));
    a_id = beat(32'hB);
    step();
    chk("stl_B_occ", 128'(a_occ), 128'(2));
    chk("stl_B_ir", 128'(a_ir), 128'(0));
    chk("stl_B_od", a_od, beat(32'hA));
    chk("stl_B_sc", 128'(a_sc), 128'(1));
    a_id = beat(32'hC);
    step();
    chk("stl_C_occ", 128'(a_occ), 128'(2));
    chk("stl_C_sc", 128'(a_sc), 128'(2));
    step();
    chk("stl_C2_sc", 128'(a_sc), 128'(3));
    a_or = 1'b1;
    #1;
    chk("rel_A_od", a_od, beat(32'hA));
    step();
    chk("rel_B_od", a_od, beat(32'hB));
    chk("rel_B_ir", 128'(a_ir), 128'(1));
    chk("rel_B_occ", 128'(a_occ), 128'(1));
    step();
    chk("rel_C_od", a_od, beat(32'hC));
    chk("rel_C_ov", 128'(a_ov), 128'(1));
    a_iv = 1'b0;
    step();
    chk("rel_end_ov", 128'(a_ov), 128'(0));
    chk("rel_sc", 128'(a_sc), 128'(3));
    a_or = 1'b0; a_iv = 1'b1; a_id = beat(32'h11);
    step();
    a_id = beat(32'h22);
    step();
    chk("fl_pre_occ", 128'(a_occ), 128'(2));
    chk("fl_pre_sc", 128'(a_sc), 128'(4));
    a_flush = 1'b1; a_or = 1'b1; a_id = beat(32'hD);
    step();
    chk("fl_ov", 128'(a_ov), 128'(0));
    chk("fl_od", a_od, 128'(0));
    chk("fl_occ", 128'(a_occ), 128'(0));
    chk("fl_ir", 128'(a_ir), 128'(1));
    chk("fl_sc", 128'(a_sc), 128'(4));
    a_flush = 1'b0; a_iv = 1'b0;
    step();
    chk("fl_noD", 128'(a_ov), 128'(0));
    a_flush = 1'b1; a_iv = 1'b1; a_id = beat(32'hE);
    step();
    chk("fl_dropE", 128'(a_ov), 128'(0));
    a_flush = 1'b0; a_iv = 1'b0;
    b_iv = 1'b1; b_id = beat(32'h5);
    step();
    b_iv = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) chk("sat_mid", 128'(b_sc), 128'(10));
    end
    chk("sat_top", 128'(b_sc), 128'(15));
    b_or = 1'b1;
    step();
    chk("sat_ov", 128'(b_ov), 128'(0));
    step();
    chk("sat_hold", 128'(b_sc), 128'(15));
    c_or = 1'b0;
    #1;
    chk("c_ir_empty", 128'(c_ir), 128'(1));
    c_iv = 1'b1; c_id = 16'h0102;
    step();
    c_iv = 1'b0;
    #1;
    chk("c_ir_full", 128'(c_ir), 128'(0));
    c_or = 1'b1;
    #1;
    chk("c_ir_comb", 128'(c_ir), 128'(1));
    chk("c_od", 128'(c_od), 128'(16'h0102));
    step();
    chk("c_drain", 128'(c_ov), 128'(0));
    snd = 0; rcv = 0;
    for (cyc = 0; cyc < 12; cyc++) begin
      c_or = cyc[0];
      c_iv = snd < 5;
      c_id = cbeat(snd);
      #1;
      if (c_ov && c_or) begin
        chk("c_alt_od", 128'(c_od), 128'(cbeat(rcv)));
        rcv++;
      end
      acc = c_iv && c_ir;
      step();
      if (acc) snd++;
    end
    chk("c_alt_snd", 128'(snd), 128'(5));
    chk("c_alt_rcv", 128'(rcv), 128'(5));
    c_iv = 1'b0;
    a_or = 1'b0; a_iv = 1'b1; a_id = beat(32'h77);
    step();
    a_iv = 1'b0;
    step();
    chk("ar_pre_ov", 128'(a_ov), 128'(1));
    chk("ar_pre_sc", 128'(a_sc), 128'(5));
    #2 clr_n = 1'b0;
    #1;
    chk("ar_ov", 128'(a_ov), 128'(0));
    chk("ar_od", a_od, 128'(0));
    chk("ar_occ", 128'(a_occ), 128'(0));
    chk("ar_sc", 128'(a_sc), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
